// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - decoder/LUT/imem bundle for the fetch-stage PC sequencer
interface pc_sequencer_if #(
  parameter int D  = 12,
  parameter int A  = 8,
  parameter int CW = 16
);
  logic          start;
  logic          stall;
  logic          branch;
  logic          cond;
  logic          call;
  logic          ret;
  logic          halt_req;
  logic [A-1:0]  lut_idx;
  logic [A-1:0]  lut_addr;
  logic [D-1:0]  lut_target;
  logic [D-1:0]  prog_ctr;
  logic          running;
  logic          done;
  logic          err;
  logic [CW-1:0] instr_cnt;

  modport master (
    output start, stall, branch, cond, call, ret, halt_req, lut_idx, lut_target,
    input  lut_addr, prog_ctr, running, done, err, instr_cnt
  );

  modport slave (
    input  start, stall, branch, cond, call, ret, halt_req, lut_idx, lut_target,
    output lut_addr, prog_ctr, running, done, err, instr_cnt
  );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter sequencer with LUT branch, single-level call/return and halt
module pc_sequencer #(
  parameter int D        = 12,
  parameter int A        = 8,
  parameter int START_PC = 0,
  parameter int CW       = 16
) (
  input logic           clk,
  input logic           reset,
  pc_sequencer_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [D-1:0] W_START = D'(START_PC);

  state_t        r_state, w_state_nxt;
  logic [D-1:0]  r_pc, w_pc_nxt;
  logic [D-1:0]  r_link, w_link_nxt;
  logic          r_link_valid, w_link_valid_nxt;
  logic          r_err, w_err_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;

  logic [D-1:0]  w_pc_inc;
  logic          w_pc_wraps;

  assign w_pc_inc   = r_pc + D'(1);
  assign w_pc_wraps = &r_pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_pc         <= W_START;
      r_link       <= '0;
      r_link_valid <= 1'b0;
      r_err        <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_link       <= w_link_nxt;
      r_link_valid <= w_link_valid_nxt;
      r_err        <= w_err_nxt;
      r_cnt        <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_link_nxt       = r_link;
    w_link_valid_nxt = r_link_valid;
    w_err_nxt        = r_err;
    w_cnt_nxt        = r_cnt;

    unique case (r_state)
      IDLE, HALT: begin
        // IDLE keeps its reset values pinned; HALT only reacts to start
        if (bus.start || (r_state == IDLE)) begin
          w_pc_nxt         = W_START;
          w_cnt_nxt        = '0;
          w_err_nxt        = 1'b0;
          w_link_valid_nxt = 1'b0;
        end
        if (bus.start) begin
          w_state_nxt = RUN;
        end
      end

      RUN: begin
        if (!bus.stall) begin
          if (r_cnt != '1) begin
            w_cnt_nxt = r_cnt + CW'(1);
          end

          if (bus.halt_req) begin
            w_state_nxt = HALT;
          end else if (bus.ret) begin
            if (r_link_valid) begin
              w_pc_nxt         = r_link;
              w_link_valid_nxt = 1'b0;
            end else begin
              w_pc_nxt  = w_pc_inc;
              w_err_nxt = 1'b1;
            end
          end else if (bus.call) begin
            // link wraps silently; only a PC increment wrap is an error
            w_link_nxt       = w_pc_inc;
            w_link_valid_nxt = 1'b1;
            w_pc_nxt         = bus.lut_target;
          end else if (bus.branch && bus.cond) begin
            w_pc_nxt = bus.lut_target;
          end else begin
            w_pc_nxt = w_pc_inc;
            if (w_pc_wraps) begin
              w_err_nxt = 1'b1;
            end
          end
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.lut_addr  = bus.lut_idx;
  assign bus.prog_ctr  = r_pc;
  assign bus.running   = (r_state == RUN);
  assign bus.done      = (r_state == HALT);
  assign bus.err       = r_err;
  assign bus.instr_cnt = r_cnt;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed vectors for pc_sequencer, full-width and 4-bit counter instances
module tb_pc_sequencer;
  localparam int D = 12;
  localparam int A = 8;

  logic          clk;
  logic          reset;
  logic          start, stall, branch, cond, call, ret, halt_req;
  logic [A-1:0]  lut_idx;
  logic [D-1:0]  lut_target;

  int n_vec  = 0;
  int n_miss = 0;

  pc_sequencer_if #(.D(D), .A(A), .CW(16)) bus_a ();
  pc_sequencer_if #(.D(D), .A(A), .CW(4))  bus_b ();

  assign bus_a.start      = start;
  assign bus_a.stall      = stall;
  assign bus_a.branch     = branch;
  assign bus_a.cond       = cond;
  assign bus_a.call       = call;
  assign bus_a.ret        = ret;
  assign bus_a.halt_req   = halt_req;
  assign bus_a.lut_idx    = lut_idx;
  assign bus_a.lut_target = lut_target;

  assign bus_b.start      = start;
  assign bus_b.stall      = stall;
  assign bus_b.branch     = branch;
  assign bus_b.cond       = cond;
  assign bus_b.call       = call;
  assign bus_b.ret        = ret;
  assign bus_b.halt_req   = halt_req;
  assign bus_b.lut_idx    = lut_idx;
  assign bus_b.lut_target = lut_target;

  pc_sequencer #(.D(D), .A(A), .START_PC(0), .CW(16)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  pc_sequencer #(.D(D), .A(A), .START_PC(0), .CW(4)) u_dut_cw4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    start = 0; stall = 0; branch = 0; cond = 0; call = 0; ret = 0; halt_req = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic check_pc(input string tag, input logic [D-1:0] pc, input logic [15:0] cnt,
                          input logic run, input logic dn, input logic er);
    check_vec({tag, ".pc"},   32'(bus_a.prog_ctr),  32'(pc));
    check_vec({tag, ".cnt"},  32'(bus_a.instr_cnt), 32'(cnt));
    check_vec({tag, ".run"},  32'(bus_a.running),   32'(run));
    check_vec({tag, ".done"}, 32'(bus_a.done),      32'(dn));
    check_vec({tag, ".err"},  32'(bus_a.err),       32'(er));
  endtask

  initial begin
    idle_inputs();
    lut_idx    = '0;
    lut_target = '0;
    reset      = 1'b0;
    #2;
    check_pc("reset", 12'h000, 16'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;

    step();
    check_pc("idle_no_start", 12'h000, 16'd0, 1'b0, 1'b0, 1'b0);

    start = 1; step();
    check_pc("start", 12'h000, 16'd0, 1'b1, 1'b0, 1'b0);
    start = 1; step();
    check_pc("start_ignored_in_run", 12'h001, 16'd1, 1'b1, 1'b0, 1'b0);
    step();
    check_pc("seq2", 12'h002, 16'd2, 1'b1, 1'b0, 1'b0);
    stall = 1; branch = 1; cond = 1; lut_target = 12'h777; step();
    check_pc("stall_hold", 12'h002, 16'd2, 1'b1, 1'b0, 1'b0);
    step();
    check_pc("seq3", 12'h003, 16'd3, 1'b1, 1'b0, 1'b0);

    branch = 1; cond = 1; lut_idx = 8'd5; lut_target = 12'h040;
    #1;
    check_vec("lut_addr", 32'(bus_a.lut_addr), 32'd5);
    step();
    check_pc("branch_taken", 12'h040, 16'd4, 1'b1, 1'b0, 1'b0);
    branch = 1; cond = 1; lut_target = 12'h003; step();
    check_pc("branch_back", 12'h003, 16'd5, 1'b1, 1'b0, 1'b0);
    branch = 1; cond = 0; lut_target = 12'h040; step();
    check_pc("branch_not_taken", 12'h004, 16'd6, 1'b1, 1'b0, 1'b0);

    branch = 1; cond = 1; lut_target = 12'h010; step();
    call = 1; lut_target = 12'h080; step();
    check_pc("call", 12'h080, 16'd8, 1'b1, 1'b0, 1'b0);
    ret = 1; call = 1; lut_target = 12'h300; step();
    check_pc("ret", 12'h011, 16'd9, 1'b1, 1'b0, 1'b0);
    ret = 1; step();
    check_pc("ret_no_link", 12'h012, 16'd10, 1'b1, 1'b0, 1'b1);
    halt_req = 1; call = 1; lut_target = 12'h123; step();
    check_pc("halt_with_call", 12'h012, 16'd11, 1'b0, 1'b1, 1'b1);
    ret = 1; branch = 1; cond = 1; step();
    check_pc("halt_ignores", 12'h012, 16'd11, 1'b0, 1'b1, 1'b1);
    start = 1; step();
    check_pc("restart", 12'h000, 16'd0, 1'b1, 1'b0, 1'b0);

    step();
    stall = 1; halt_req = 1; step();
    check_pc("stall_halt", 12'h001, 16'd1, 1'b1, 1'b0, 1'b0);
    halt_req = 1; step();
    check_pc("halt", 12'h001, 16'd2, 1'b0, 1'b1, 1'b0);
    start = 1; step();
    check_pc("restart2", 12'h000, 16'd0, 1'b1, 1'b0, 1'b0);

    branch = 1; cond = 1; lut_target = 12'hFFF; step();
    check_pc("to_fff", 12'hFFF, 16'd1, 1'b1, 1'b0, 1'b0);
    step();
    check_pc("wrap", 12'h000, 16'd2, 1'b1, 1'b0, 1'b1);

    halt_req = 1; step();
    start = 1; step();
    branch = 1; cond = 1; lut_target = 12'hFFF; step();
    call = 1; lut_target = 12'h050; step();
    check_pc("call_at_fff", 12'h050, 16'd2, 1'b1, 1'b0, 1'b0);
    ret = 1; step();
    check_pc("ret_link_wrap", 12'h000, 16'd3, 1'b1, 1'b0, 1'b0);

    halt_req = 1; step();
    start = 1; step();
    for (int i = 0; i < 20; i++) step();
    check_pc("run20", 12'h014, 16'd20, 1'b1, 1'b0, 1'b0);
    check_vec("cw4_saturate", 32'(bus_b.instr_cnt), 32'd15);

    halt_req = 1; step();
    start = 1; step();
    for (int i = 0; i < 5; i++) step();
    check_pc("pre_reset", 12'h005, 16'd5, 1'b1, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check_pc("async_reset", 12'h000, 16'd0, 1'b0, 1'b0, 1'b0);
    check_vec("async_reset.cw4", 32'(bus_b.instr_cnt), 32'd0);
    #1;
    reset = 1'b1;
    step();
    check_pc("idle_after_reset", 12'h000, 16'd0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
